// File: rtl/fpsu_ret_collect_pkg.sv
// Shared FPU retire-path definitions: default word width, lane encodings and
// the round-robin lane successor used by the retire collector.
package fpsu_ret_collect_pkg;

  localparam int RET_W_DEF = 14;
  localparam int NUM_LANES = 3;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_U1 = 2'd0;
  localparam lane_t LANE_U3 = 2'd1;
  localparam lane_t LANE_U5 = 2'd2;

  // Successor of a lane in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic lane_t rr_next(input lane_t lane);
    case (lane)
      LANE_U1: rr_next = LANE_U3;
      LANE_U3: rr_next = LANE_U5;
      default: rr_next = LANE_U1;
    endcase
  endfunction

endpackage

// File: rtl/fpsu_ret_fifo.sv
// Per-lane retire FIFO. A push into a full FIFO lands only when the same
// cycle also pops; flush clears pointers/count and drops the cycle's traffic.
module fpsu_ret_fifo #(
  parameter int DEPTH = 4,
  parameter int RET_W = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [RET_W-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [RET_W-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [RET_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == {CW{1'b0}});
  assign count     = r_count;
  assign head      = r_mem[r_rptr];
  assign w_pop_ok  = pop && !empty && !flush;
  assign w_push_ok = push && !flush && (!full || w_pop_ok);

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (flush) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
      if (w_pop_ok)  r_rptr <= r_rptr + {{(AW-1){1'b0}}, 1'b1};
      r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
    end
  end

  // Storage array, deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/fpsu_ret_collect.sv
// Collects retire words from the three FP store/shuffle lanes and presents
// them one at a time through a round-robin arbiter with a hold-until-accept lock.
module fpsu_ret_collect
  import fpsu_ret_collect_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RET_W = RET_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [RET_W-1:0] u1_ret,
  input  logic [RET_W-1:0] u3_ret,
  input  logic [RET_W-1:0] u5_ret,
  input  logic             u1_ret_en,
  input  logic             u3_ret_en,
  input  logic             u5_ret_en,
  output logic             ret_valid,
  input  logic             ret_ready,
  output logic [RET_W-1:0] ret_data,
  output logic [1:0]       ret_lane,
  output logic [2:0]       ovf,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]       w_push;
  logic [2:0]       w_pop;
  logic [2:0]       w_full;
  logic [2:0]       w_empty;
  logic [3:0]       w_ne;
  logic [RET_W-1:0] w_din  [NUM_LANES];
  logic [RET_W-1:0] w_head [NUM_LANES];
  logic [CW-1:0]    w_count [NUM_LANES];
  lane_t            w_c0, w_c1, w_c2, w_pick, w_winner;
  logic [RET_W-1:0] w_head_sel;
  logic             w_accept;

  lane_t            r_rr_ptr;
  logic             r_lock;
  lane_t            r_lock_lane;
  logic [2:0]       r_ovf;

  assign w_push   = {u5_ret_en, u3_ret_en, u1_ret_en};
  assign w_din[0] = u1_ret;
  assign w_din[1] = u3_ret;
  assign w_din[2] = u5_ret;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fpsu_ret_fifo #(.DEPTH(DEPTH), .RET_W(RET_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (w_push[g]),
      .pop   (w_pop[g]),
      .din   (w_din[g]),
      .full  (w_full[g]),
      .empty (w_empty[g]),
      .count (w_count[g]),
      .head  (w_head[g])
    );
    assign w_pop[g] = w_accept && (w_winner == 2'(g));
    assign w_ne[g]  = (w_count[g] != {CW{1'b0}});
  end
  assign w_ne[3] = 1'b0;

  assign busy     = ~&w_empty;
  assign w_accept = busy && ret_ready && !flush;

  // Winner: locked lane while a presented word waits, else first non-empty from rr_ptr.
  always_comb begin
    w_c0 = r_rr_ptr;
    w_c1 = rr_next(w_c0);
    w_c2 = rr_next(w_c1);
    if (w_ne[w_c0]) begin
      w_pick = w_c0;
    end else if (w_ne[w_c1]) begin
      w_pick = w_c1;
    end else begin
      w_pick = w_c2;
    end
    if (r_lock) begin
      w_winner = r_lock_lane;
    end else begin
      w_winner = w_pick;
    end
  end

  // Head mux for the winning lane.
  always_comb begin
    case (w_winner)
      LANE_U1: w_head_sel = w_head[0];
      LANE_U3: w_head_sel = w_head[1];
      LANE_U5: w_head_sel = w_head[2];
      default: w_head_sel = {RET_W{1'b0}};
    endcase
  end

  assign ret_valid = busy;
  assign ret_data  = busy ? w_head_sel : {RET_W{1'b0}};
  assign ret_lane  = busy ? w_winner : LANE_U1;
  assign ovf       = r_ovf;

  // Round-robin pointer, grant lock and sticky overflow flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= LANE_U1;
      r_lock      <= 1'b0;
      r_lock_lane <= LANE_U1;
      r_ovf       <= 3'b000;
    end else if (flush) begin
      r_rr_ptr    <= LANE_U1;
      r_lock      <= 1'b0;
      r_lock_lane <= LANE_U1;
      r_ovf       <= 3'b000;
    end else begin
      if (w_accept) r_rr_ptr <= rr_next(w_winner);
      r_lock      <= busy && !ret_ready;
      r_lock_lane <= w_winner;
      r_ovf       <= r_ovf | (w_push & w_full & ~w_pop);
    end
  end

endmodule

// File: tb/tb_fpsu_ret_collect.sv
// Directed self-checking bench for fpsu_ret_collect (DEPTH=4, RET_W=14).
module tb_fpsu_ret_collect;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [13:0] u1_ret = 14'h0, u3_ret = 14'h0, u5_ret = 14'h0;
  logic        u1_ret_en = 1'b0, u3_ret_en = 1'b0, u5_ret_en = 1'b0;
  logic        ret_ready = 1'b0;
  logic        ret_valid;
  logic [13:0] ret_data;
  logic [1:0]  ret_lane;
  logic [2:0]  ovf;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  fpsu_ret_collect #(.DEPTH(4), .RET_W(14)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .u1_ret(u1_ret), .u3_ret(u3_ret), .u5_ret(u5_ret),
    .u1_ret_en(u1_ret_en), .u3_ret_en(u3_ret_en), .u5_ret_en(u5_ret_en),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_data(ret_data),
    .ret_lane(ret_lane), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    {u1_ret_en, u3_ret_en, u5_ret_en, ret_ready, flush} = 5'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_chk++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", ret_valid); end
    n_chk++; if (ret_data !== 14'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", ret_data); end
    n_chk++; if (ret_lane !== 2'd0) begin n_fail++; $display("FAIL reset_lane: got %0d exp 0", ret_lane); end
    n_chk++; if (ovf !== 3'b000) begin n_fail++; $display("FAIL reset_ovf: got %b exp 000", ovf); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    ret_ready = 1'b1; u1_ret = 14'h0012; u1_ret_en = 1'b1;
    n_chk++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL single_comb_path: got %b exp 0", ret_valid); end
    tick();
    u1_ret_en = 1'b0;
    n_chk++; if (ret_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b exp 1", ret_valid); end
    n_chk++; if (ret_data !== 14'h0012) begin n_fail++; $display("FAIL single_data: got %h exp 0012", ret_data); end
    n_chk++; if (ret_lane !== 2'd0) begin n_fail++; $display("FAIL single_lane: got %0d exp 0", ret_lane); end
    tick();
    n_chk++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b exp 0", ret_valid); end
  endtask

  task automatic test_all_three();
    logic [13:0] exp_d [3];
    exp_d[0] = 14'h0001; exp_d[1] = 14'h0002; exp_d[2] = 14'h0003;
    do_reset();
    ret_ready = 1'b1;
    u1_ret = 14'h0001; u3_ret = 14'h0002; u5_ret = 14'h0003;
    {u1_ret_en, u3_ret_en, u5_ret_en} = 3'b111;
    tick();
    {u1_ret_en, u3_ret_en, u5_ret_en} = 3'b000;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (ret_valid !== 1'b1 || ret_lane !== 2'(i) || ret_data !== exp_d[i]) begin
        n_fail++; $display("FAIL all3_out%0d: got v=%b lane=%0d data=%h exp v=1 lane=%0d data=%h", i, ret_valid, ret_lane, ret_data, i, exp_d[i]);
      end
      tick();
    end
    n_chk++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL all3_drained: got %b exp 0", ret_valid); end
  endtask

  task automatic test_lock();
    do_reset();
    u3_ret = 14'h0AAA; u3_ret_en = 1'b1;
    tick();
    u3_ret_en = 1'b0;
    n_chk++; if (ret_lane !== 2'd1 || ret_data !== 14'h0AAA) begin n_fail++; $display("FAIL lock_first: got lane=%0d data=%h exp lane=1 data=0aaa", ret_lane, ret_data); end
    u1_ret = 14'h0111; u1_ret_en = 1'b1;
    tick();
    u1_ret_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (ret_valid !== 1'b1 || ret_lane !== 2'd1 || ret_data !== 14'h0AAA) begin
        n_fail++; $display("FAIL lock_hold%0d: got v=%b lane=%0d data=%h exp v=1 lane=1 data=0aaa", i, ret_valid, ret_lane, ret_data);
      end
      tick();
    end
    ret_ready = 1'b1;
    tick();
    n_chk++; if (ret_lane !== 2'd0 || ret_data !== 14'h0111) begin n_fail++; $display("FAIL lock_next: got lane=%0d data=%h exp lane=0 data=0111", ret_lane, ret_data); end
    tick();
    n_chk++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL lock_drained: got %b exp 0", ret_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      u5_ret = 14'h0501 + 14'(i); u5_ret_en = 1'b1;
      tick();
    end
    u5_ret_en = 1'b0;
    n_chk++; if (ovf !== 3'b100) begin n_fail++; $display("FAIL ovf_flag: got %b exp 100", ovf); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (ret_valid !== 1'b1 || ret_lane !== 2'd2 || ret_data !== 14'h0501 + 14'(i)) begin
        n_fail++; $display("FAIL ovf_drain%0d: got v=%b lane=%0d data=%h exp v=1 lane=2 data=%h", i, ret_valid, ret_lane, ret_data, 14'h0501 + 14'(i));
      end
      ret_ready = 1'b1;
      tick();
    end
    n_chk++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_fifth_dropped: got v=%b data=%h exp v=0", ret_valid, ret_data); end
    n_chk++; if (ovf !== 3'b100) begin n_fail++; $display("FAIL ovf_sticky: got %b exp 100", ovf); end
  endtask

  task automatic test_full_pushpop();
    logic [13:0] exp_d [4];
    exp_d[0] = 14'h0042; exp_d[1] = 14'h0043; exp_d[2] = 14'h0044; exp_d[3] = 14'h0055;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      u1_ret = 14'h0041 + 14'(i); u1_ret_en = 1'b1;
      tick();
    end
    ret_ready = 1'b1; u1_ret = 14'h0055; u1_ret_en = 1'b1;
    tick();
    u1_ret_en = 1'b0;
    n_chk++; if (ovf !== 3'b000) begin n_fail++; $display("FAIL pushpop_no_ovf: got %b exp 000", ovf); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (ret_valid !== 1'b1 || ret_lane !== 2'd0 || ret_data !== exp_d[i]) begin
        n_fail++; $display("FAIL pushpop_order%0d: got v=%b lane=%0d data=%h exp v=1 lane=0 data=%h", i, ret_valid, ret_lane, ret_data, exp_d[i]);
      end
      tick();
    end
    n_chk++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_drained: got %b exp 0", ret_valid); end
  endtask

  task automatic test_flush_and_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      u1_ret = 14'h0031 + 14'(i); u1_ret_en = 1'b1;
      tick();
    end
    u1_ret_en = 1'b0;
    n_chk++; if (ovf !== 3'b001) begin n_fail++; $display("FAIL flush_pre_ovf: got %b exp 001", ovf); end
    ret_ready = 1'b1;
    tick(); tick();
    ret_ready = 1'b0;
    n_chk++; if (ret_data !== 14'h0033) begin n_fail++; $display("FAIL flush_pre_head: got %h exp 0033", ret_data); end
    flush = 1'b1; ret_ready = 1'b1; u3_ret = 14'h0777; u3_ret_en = 1'b1;
    tick();
    flush = 1'b0; ret_ready = 1'b0; u3_ret_en = 1'b0;
    n_chk++; if (ret_valid !== 1'b0 || busy !== 1'b0 || ovf !== 3'b000 || ret_data !== 14'h0 || ret_lane !== 2'd0) begin
      n_fail++; $display("FAIL flush_clear: got v=%b busy=%b ovf=%b data=%h lane=%0d exp all 0", ret_valid, busy, ovf, ret_data, ret_lane);
    end
    tick();
    n_chk++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL flush_push_dropped: got %b exp 0", ret_valid); end
    u1_ret = 14'h0201; u3_ret = 14'h0202; u1_ret_en = 1'b1; u3_ret_en = 1'b1; ret_ready = 1'b1;
    tick();
    u1_ret_en = 1'b0; u3_ret_en = 1'b0;
    n_chk++; if (ret_valid !== 1'b1 || ret_data !== 14'h0201) begin n_fail++; $display("FAIL rst_pre_drain: got v=%b data=%h exp v=1 data=0201", ret_valid, ret_data); end
    rst = 1'b0;
    #1;
    n_chk++; if (ret_valid !== 1'b0 || busy !== 1'b0 || ovf !== 3'b000 || ret_data !== 14'h0 || ret_lane !== 2'd0) begin
      n_fail++; $display("FAIL rst_async: got v=%b busy=%b ovf=%b data=%h lane=%0d exp all 0", ret_valid, busy, ovf, ret_data, ret_lane);
    end
    @(negedge clk);
    rst = 1'b1;
    u1_ret = 14'h0123; u1_ret_en = 1'b1;
    #1;
    n_chk++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL rst_post_empty: got %b exp 0", ret_valid); end
    tick();
    u1_ret_en = 1'b0;
    n_chk++; if (ret_valid !== 1'b1 || ret_data !== 14'h0123 || ret_lane !== 2'd0) begin
      n_fail++; $display("FAIL rst_post_push: got v=%b data=%h lane=%0d exp v=1 data=0123 lane=0", ret_valid, ret_data, ret_lane);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_lock();
    test_overflow();
    test_full_pushpop();
    test_flush_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpsu_ret_collect.md
FPSU_RET_COLLECT -- requirements
Module: fpsu_ret_collect

Interface
REQ-001 SHALL have parameter DEPTH, default 4, per-lane FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RET_W, default 14, retire-word width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of all queued state.
REQ-006 SHALL have ports u1_ret, u3_ret, u5_ret  input  RET_W each  retire words from FP store/shuffle lanes 0/1/2.
REQ-007 SHALL have ports u1_ret_en, u3_ret_en, u5_ret_en  input  1 each  push strobe per lane, no backpressure.
REQ-008 SHALL have port ret_valid  output  1  a retire word is presented.
REQ-009 SHALL have port ret_ready  input  1  consumer accepts on ret_valid&&ret_ready.
REQ-010 SHALL have port ret_data  output  RET_W  presented word.
REQ-011 SHALL have port ret_lane  output  2  source lane 0/1/2 of ret_data.
REQ-012 SHALL have port ovf  output  3  sticky per-lane overflow flags.
REQ-013 SHALL have port busy  output  1  OR of all lane non-empty.

Function
REQ-014 SHALL hold one FIFO per lane; push when lane strobe high, pop when that lane wins and is accepted.
REQ-015 SHALL make a word pushed in cycle N eligible on ret_valid no earlier than cycle N+1 (no input-to-output combinational path).
REQ-016 SHALL keep each lane's words in push order; no ordering across lanes.
REQ-017 SHALL arbitrate round-robin: winner is first non-empty lane at or after rr_ptr (0->1->2->0); rr_ptr resets to 0.
REQ-018 SHALL set rr_ptr to (winner+1) mod 3 on each accept; unchanged otherwise.
REQ-019 SHALL lock the grant while ret_valid&&!ret_ready; ret_data/ret_lane stay stable until accept, even if other lanes fill.
REQ-020 SHALL drive ret_valid=busy; ret_data and ret_lane = winner's head and index; both zero when !ret_valid.
REQ-021 SHALL accept a push on a full lane only when that lane pops the same cycle; count unchanged.
REQ-022 SHALL otherwise drop a push on a full lane, set the lane's ovf bit, leave FIFO contents unchanged.
REQ-023 SHALL clear ovf only by flush or reset.
REQ-024 SHALL handle push and pop on the same non-full lane in one cycle with count unchanged.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; count width clog2(DEPTH)+1.
REQ-026 SHALL on flush empty all FIFOs, clear ovf, set rr_ptr=0, release the lock, drop same-cycle pushes, ignore ret_ready; ret_valid=0 the next cycle.
REQ-027 SHALL accept all three lanes pushing in one cycle without loss if none full.

Reset
REQ-028 SHALL on rst low asynchronously force: all FIFOs empty, rr_ptr=0, lock released, ovf=3'b000, ret_valid=0, ret_data=0, ret_lane=0, busy=0.
REQ-029 SHALL mid-operation reset discard queued words; first push after release appears one cycle later as in REQ-015.
REQ-030 SHALL leave FIFO storage arrays unreset; only pointers/counts/flags reset.

Structure
REQ-031 SHALL put RET_W default, lane-index encodings (0/1/2) and the round-robin next-lane function in the shared FPU package.
REQ-032 SHALL instantiate one sub-module fpsu_ret_fifo (parameterised DEPTH/RET_W, push/pop/full/empty/count/head) three times.
REQ-033 SHALL keep arbiter, lock and ovf logic in fpsu_ret_collect.

Verification
REQ-034 SHALL test: reset, then u1 push 14'h0012 at cycle 0, ret_ready=1 -> cycle 1 ret_valid=1, ret_data=14'h0012, ret_lane=0; cycle 2 ret_valid=0.
REQ-035 SHALL test: all three lanes push 14'h0001/14'h0002/14'h0003 in one cycle, ret_ready=1 -> output lanes 0,1,2 on three consecutive cycles.
REQ-036 SHALL test: ret_ready=0, lane 1 word 14'h0AAA presented, then lane 0 push -> ret_lane=1, ret_data=14'h0AAA held stable until ready.
REQ-037 SHALL test: ret_ready=0, 5 pushes on u5 with DEPTH=4 -> ovf=3'b100, the first 4 words then drain in order; 5th never appears.
REQ-038 SHALL test: full lane 0 with simultaneous pop and push 14'h0055 -> no ovf, 14'h0055 appears last in lane 0 order.
REQ-039 SHALL test: flush with 2 words queued and ovf=3'b001 -> next cycle ret_valid=0, busy=0, ovf=0; rst low mid-drain -> all outputs 0 immediately.
